// File: rtl/mac_iter_sched_pkg.sv
// Shared types and constants for the MAC iteration scheduler.
// Struct field widths follow the package defaults, which are also the scheduler's default parameters.
package mac_iter_sched_pkg;

    localparam int unsigned CNT_LEN = 1024;
    localparam int unsigned LEN_W   = $clog2(CNT_LEN) + 1;
    localparam int unsigned ITER_W  = 16;
    localparam int unsigned ADDR_W  = 32;
    localparam int unsigned SHIFT_W = 5;
    localparam int unsigned N_PTR   = 4;

    typedef enum logic [2:0] {
        IDLE,
        START,
        COMPUTE,
        WAIT,
        UPDATEIDX,
        TERMINATE
    } state_fsm_t;

    typedef struct packed {
        logic [ITER_W-1:0]  nb_iter;
        logic [LEN_W-1:0]   len;
        logic [ADDR_W-1:0]  stride;
        logic [SHIFT_W-1:0] shift;
        logic               simple_mul;
        logic [ADDR_W-1:0]  base_a;
        logic [ADDR_W-1:0]  base_b;
        logic [ADDR_W-1:0]  base_c;
        logic [ADDR_W-1:0]  base_d;
    } ctrl_sched_t;

    typedef struct packed {
        logic              busy;
        logic              done;
        logic [ITER_W-1:0] iter;
    } flags_sched_t;

    // c/d hold one scalar result per iteration, unless every element is written back.
    function automatic logic [ADDR_W-1:0] cd_step(input logic simple_mul,
                                                  input logic [ADDR_W-1:0] stride);
        return simple_mul ? stride : ADDR_W'(4);
    endfunction

endpackage

// File: rtl/mac_iter_addrgen.sv
// Four per-pointer address accumulators: load from bases, advance by per-pointer step, clear.
module mac_iter_addrgen
    import mac_iter_sched_pkg::*;
#(
    parameter int unsigned ADDR_W = mac_iter_sched_pkg::ADDR_W
) (
    input  logic                         clk_i,
    input  logic                         rst_ni,
    input  logic                         clear_i,
    input  logic                         load_i,
    input  logic                         advance_i,
    input  logic [N_PTR-1:0][ADDR_W-1:0] base_i,
    input  logic [N_PTR-1:0][ADDR_W-1:0] inc_i,
    output logic [N_PTR-1:0][ADDR_W-1:0] addr_o
);

    logic [N_PTR-1:0][ADDR_W-1:0] addr_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            addr_q <= '0;
        end else if (clear_i) begin
            addr_q <= '0;
        end else if (load_i) begin
            addr_q <= base_i;
        end else if (advance_i) begin
            for (int unsigned p = 0; p < N_PTR; p++) begin
                addr_q[p] <= addr_q[p] + inc_i[p];
            end
        end
    end

    assign addr_o = addr_q;

endmodule

// File: rtl/mac_iter_sched.sv
// Iteration scheduler: launches streamers and engine once per iteration, waits for
// engine completion and sink drain, advances addresses, and pulses done_o at job end.
module mac_iter_sched
    import mac_iter_sched_pkg::*;
#(
    parameter  int unsigned CNT_LEN = mac_iter_sched_pkg::CNT_LEN,
    parameter  int unsigned ITER_W  = mac_iter_sched_pkg::ITER_W,
    parameter  int unsigned ADDR_W  = mac_iter_sched_pkg::ADDR_W,
    localparam int unsigned LW      = $clog2(CNT_LEN) + 1
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              clear_i,
    input  logic              start_i,
    output logic              busy_o,
    output logic              done_o,
    input  logic [ITER_W-1:0] cfg_nb_iter_i,
    input  logic [LW-1:0]     cfg_len_i,
    input  logic [ADDR_W-1:0] cfg_stride_i,
    input  logic [4:0]        cfg_shift_i,
    input  logic              cfg_simple_mul_i,
    input  logic [ADDR_W-1:0] cfg_base_a_i,
    input  logic [ADDR_W-1:0] cfg_base_b_i,
    input  logic [ADDR_W-1:0] cfg_base_c_i,
    input  logic [ADDR_W-1:0] cfg_base_d_i,
    output logic              eng_clear_o,
    output logic              eng_start_o,
    output logic              eng_enable_o,
    output logic [LW-1:0]     eng_len_o,
    output logic [4:0]        eng_shift_o,
    output logic              eng_simple_mul_o,
    input  logic [LW-1:0]     eng_cnt_i,
    input  logic              strm_ready_i,
    output logic              strm_req_o,
    output logic [ADDR_W-1:0] strm_addr_a_o,
    output logic [ADDR_W-1:0] strm_addr_b_o,
    output logic [ADDR_W-1:0] strm_addr_c_o,
    output logic [ADDR_W-1:0] strm_addr_d_o,
    output logic [LW-1:0]     strm_len_o,
    input  logic              sink_done_i
);

    state_fsm_t   state_q, state_d;
    ctrl_sched_t  ctrl_q, ctrl_in;
    flags_sched_t flags;
    logic [ITER_W-1:0] iter_q, iter_inc;
    logic sink_done_q, sink_seen, job_start, sink_window;

    logic [N_PTR-1:0][ADDR_W-1:0] base_vec, inc_vec, addr_vec;

    assign job_start   = (state_q == IDLE) && start_i;
    assign sink_seen   = sink_done_q || sink_done_i;
    assign sink_window = (state_q == START) || (state_q == COMPUTE) || (state_q == WAIT);
    assign iter_inc    = flags.iter + ITER_W'(1);

    always_comb begin
        ctrl_in            = '0;
        ctrl_in.nb_iter    = cfg_nb_iter_i;
        ctrl_in.len        = cfg_len_i;
        ctrl_in.stride     = cfg_stride_i;
        ctrl_in.shift      = cfg_shift_i;
        ctrl_in.simple_mul = cfg_simple_mul_i;
        ctrl_in.base_a     = cfg_base_a_i;
        ctrl_in.base_b     = cfg_base_b_i;
        ctrl_in.base_c     = cfg_base_c_i;
        ctrl_in.base_d     = cfg_base_d_i;
    end

    always_comb begin
        flags      = '0;
        flags.busy = (state_q != IDLE);
        flags.done = (state_q == TERMINATE);
        flags.iter = iter_q;
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: begin
                if (start_i) begin
                    state_d = (cfg_nb_iter_i == '0 || cfg_len_i == '0) ? TERMINATE : START;
                end
            end
            START:     if (strm_ready_i) state_d = COMPUTE;
            COMPUTE:   if (eng_cnt_i == ctrl_q.len) state_d = WAIT;
            // A sink pulse arriving in WAIT itself is taken directly, not via the flag.
            WAIT:      if (sink_seen) state_d = UPDATEIDX;
            UPDATEIDX: state_d = (iter_inc == ctrl_q.nb_iter) ? TERMINATE : START;
            TERMINATE: state_d = IDLE;
            default:   state_d = IDLE;
        endcase
        if (clear_i) begin
            state_d = IDLE;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q     <= IDLE;
            ctrl_q      <= '0;
            iter_q      <= '0;
            sink_done_q <= 1'b0;
        end else begin
            state_q <= state_d;
            if (clear_i) begin
                iter_q      <= '0;
                sink_done_q <= 1'b0;
            end else begin
                if (job_start) begin
                    ctrl_q <= ctrl_in;
                    iter_q <= '0;
                end else if (state_q == UPDATEIDX) begin
                    iter_q <= iter_inc;
                end
                if (state_d == UPDATEIDX) begin
                    sink_done_q <= 1'b0;
                end else if (sink_done_i && sink_window) begin
                    sink_done_q <= 1'b1;
                end
            end
        end
    end

    assign base_vec = {cfg_base_d_i, cfg_base_c_i, cfg_base_b_i, cfg_base_a_i};
    assign inc_vec  = {cd_step(ctrl_q.simple_mul, ctrl_q.stride),
                       cd_step(ctrl_q.simple_mul, ctrl_q.stride),
                       ctrl_q.stride,
                       ctrl_q.stride};

    mac_iter_addrgen #(
        .ADDR_W (ADDR_W)
    ) i_addrgen (
        .clk_i     (clk_i),
        .rst_ni    (rst_ni),
        .clear_i   (clear_i),
        .load_i    (job_start),
        .advance_i (state_q == UPDATEIDX),
        .base_i    (base_vec),
        .inc_i     (inc_vec),
        .addr_o    (addr_vec)
    );

    assign busy_o           = flags.busy;
    assign done_o           = flags.done;
    assign eng_clear_o      = (state_q == IDLE) || (state_q == UPDATEIDX);
    assign eng_start_o      = (state_q == START) && strm_ready_i;
    assign strm_req_o       = (state_q == START) && strm_ready_i;
    assign eng_enable_o     = (state_q == COMPUTE);
    assign eng_len_o        = ctrl_q.len;
    assign eng_shift_o      = ctrl_q.shift;
    assign eng_simple_mul_o = ctrl_q.simple_mul;
    assign strm_len_o       = ctrl_q.len;
    assign strm_addr_a_o    = addr_vec[0];
    assign strm_addr_b_o    = addr_vec[1];
    assign strm_addr_c_o    = addr_vec[2];
    assign strm_addr_d_o    = addr_vec[3];

endmodule
